gpio_wrapper: RTL and testbench

//  Multi-port, bidirectional GPIO peripheral on the 6502 system bus. It has the same
//  cs/we/addr/din/dout interface as uart_wrapper and spi_wrapper.

---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_port.sv | 95 +++++++++
 rtl/gpio_wrapper.sv | 104 ++++++++++
 tb/tb_gpio_wrapper.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Register offsets and flag-update helper shared by the GPIO block
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_OUT  = 3'd0,
    GPIO_DIR  = 3'd1,
    GPIO_IN   = 3'd2,
    GPIO_SET  = 3'd3,
    GPIO_CLR  = 3'd4,
    GPIO_IE   = 3'd5,
    GPIO_EDGE = 3'd6,
    GPIO_FLAG = 3'd7
  } gpio_reg_e;

  // A new edge overrides a same-cycle write-one-to-clear.
  function automatic logic [7:0] gpio_flag_next(input logic [7:0] flag,
                                                input logic [7:0] clr,
                                                input logic [7:0] set);
    return (flag & ~clr) | set;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_port
// Description : One 8-bit GPIO port: registers, input synchroniser, edge flags
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_port
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_arm,
  input  logic       i_wr_en,
  input  gpio_reg_e  i_reg_sel,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_pin,
  output logic [7:0] o_rdata,
  output logic [7:0] o_out,
  output logic [7:0] o_dir,
  output logic [7:0] o_irq_src
);

  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] r_in_d;
  logic [7:0] r_out;
  logic [7:0] r_dir;
  logic [7:0] r_ie;
  logic [7:0] r_edge;
  logic [7:0] r_flag;

  logic [7:0] w_in_q;
  logic [7:0] w_evt;
  logic [7:0] w_clr;

  assign w_in_q = r_sync[SYNC_STAGES-1];

  // Per-bit edge select: EDGE=0 picks rising, EDGE=1 picks falling.
  assign w_evt = i_arm ? ((w_in_q & ~r_in_d & ~r_edge) | (~w_in_q & r_in_d & r_edge)) : 8'h00;
  assign w_clr = (i_wr_en && (i_reg_sel == GPIO_FLAG)) ? i_wdata : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= 8'h00;
      end
      r_in_d <= 8'h00;
      r_out  <= 8'h00;
      r_dir  <= 8'h00;
      r_ie   <= 8'h00;
      r_edge <= 8'h00;
      r_flag <= 8'h00;
    end else begin
      r_sync[0] <= i_pin;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_in_d <= w_in_q;
      r_flag <= gpio_flag_next(r_flag, w_clr, w_evt);
      if (i_wr_en) begin
        case (i_reg_sel)
          GPIO_OUT:  r_out  <= i_wdata;
          GPIO_DIR:  r_dir  <= i_wdata;
          GPIO_SET:  r_out  <= r_out | i_wdata;
          GPIO_CLR:  r_out  <= r_out & ~i_wdata;
          GPIO_IE:   r_ie   <= i_wdata;
          GPIO_EDGE: r_edge <= i_wdata;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = 8'h00;
    case (i_reg_sel)
      GPIO_OUT,
      GPIO_SET,
      GPIO_CLR:  o_rdata = r_out;
      GPIO_DIR:  o_rdata = r_dir;
      GPIO_IN:   o_rdata = w_in_q;
      GPIO_IE:   o_rdata = r_ie;
      GPIO_EDGE: o_rdata = r_edge;
      GPIO_FLAG: o_rdata = r_flag;
      default:   o_rdata = 8'h00;
    endcase
  end

  assign o_out     = r_out;
  assign o_dir     = r_dir;
  assign o_irq_src = r_flag & r_ie;

endmodule
`default_nettype wire

// File: rtl/gpio_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : gpio_wrapper
// Description : Multi-port GPIO peripheral on the 6502 bus with edge interrupts
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_wrapper
  import gpio_pkg::*;
#(
  parameter int PORTS       = 2,
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  input  logic [8*PORTS-1:0]   gpio_i,
  output logic [8*PORTS-1:0]   gpio_o,
  output logic [8*PORTS-1:0]   gpio_oe,
  output logic                 irq
);

  localparam int c_pidx_w  = (ADDR_W > 3) ? ADDR_W - 3 : 1;
  localparam int c_arm_max = SYNC_STAGES + 1;
  localparam int c_arm_w   = $clog2(c_arm_max + 1);

  logic [c_pidx_w-1:0] w_pidx;
  gpio_reg_e           w_reg;
  logic [7:0]          w_rdata   [PORTS];
  logic [7:0]          w_irq_src [PORTS];
  logic [7:0]          w_dout;
  logic                w_irq_any;
  logic                w_arm;
  logic [c_arm_w-1:0]  r_arm_cnt;
  logic [7:0]          r_dout;
  logic                r_irq;

  if (ADDR_W > 3) begin : g_pidx
    assign w_pidx = addr[ADDR_W-1:3];
  end else begin : g_pidx_single
    assign w_pidx = '0;
  end

  assign w_reg = gpio_reg_e'(addr[2:0]);
  assign w_arm = (r_arm_cnt == c_arm_w'(c_arm_max));

  // Holds edge detection off until the synchroniser and in_d hold real pad data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
    end else if (!w_arm) begin
      r_arm_cnt <= r_arm_cnt + c_arm_w'(1);
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    gpio_port #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_arm     (w_arm),
      .i_wr_en   (cs && we && (w_pidx == c_pidx_w'(p))),
      .i_reg_sel (w_reg),
      .i_wdata   (din),
      .i_pin     (gpio_i[8*p +: 8]),
      .o_rdata   (w_rdata[p]),
      .o_out     (gpio_o[8*p +: 8]),
      .o_dir     (gpio_oe[8*p +: 8]),
      .o_irq_src (w_irq_src[p])
    );
  end

  // Unpopulated port indices fall through to 0x00.
  always_comb begin
    w_dout    = 8'h00;
    w_irq_any = 1'b0;
    for (int p = 0; p < PORTS; p++) begin
      if (w_pidx == c_pidx_w'(p)) begin
        w_dout = w_rdata[p];
      end
      w_irq_any = w_irq_any | (|w_irq_src[p]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= 8'h00;
      r_irq  <= 1'b0;
    end else begin
      r_dout <= w_dout;
      r_irq  <= w_irq_any;
    end
  end

  assign dout = r_dout;
  assign irq  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_wrapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_wrapper
// Description : Self-checking bench for gpio_wrapper against a behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_wrapper;

  localparam int PORTS = 2;
  localparam int AW    = 5;
  localparam int S     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cs = 1'b0;
  logic             we = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [7:0]       din = '0;
  logic [7:0]       dout;
  logic [8*PORTS-1:0] gpio_i = '0;
  logic [8*PORTS-1:0] gpio_o;
  logic [8*PORTS-1:0] gpio_oe;
  logic             irq;

  int n_pass = 0;
  int n_total = 0;

  gpio_wrapper #(.PORTS(PORTS), .ADDR_W(AW), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: register file plus a history of sampled pad values.
  logic [7:0] m_out [PORTS];
  logic [7:0] m_dir [PORTS];
  logic [7:0] m_ie  [PORTS];
  logic [7:0] m_edg [PORTS];
  logic [7:0] m_flag[PORTS];
  logic [7:0] m_dout;
  logic       m_irq;
  int         m_edges;
  logic [8*PORTS-1:0] m_hist[$];

  task automatic model_reset();
    for (int q = 0; q < PORTS; q++) begin
      m_out[q] = 0; m_dir[q] = 0; m_ie[q] = 0; m_edg[q] = 0; m_flag[q] = 0;
    end
    m_dout = 0; m_irq = 0; m_edges = 0;
    m_hist.delete();
    for (int k = 0; k <= S; k++) m_hist.push_back('0);
  endtask

  function automatic logic [7:0] m_read(int p, int r);
    if (p >= PORTS) return 8'h00;
    case (r)
      0, 3, 4: return m_out[p];
      1:       return m_dir[p];
      2:       return m_hist[S-1][8*p +: 8];
      5:       return m_ie[p];
      6:       return m_edg[p];
      default: return m_flag[p];
    endcase
  endfunction

  function automatic logic [8*PORTS-1:0] m_gpio_o();
    logic [8*PORTS-1:0] v;
    for (int q = 0; q < PORTS; q++) v[8*q +: 8] = m_out[q];
    return v;
  endfunction

  function automatic logic [8*PORTS-1:0] m_gpio_oe();
    logic [8*PORTS-1:0] v;
    for (int q = 0; q < PORTS; q++) v[8*q +: 8] = m_dir[q];
    return v;
  endfunction

  // Advance model and DUT by one clock edge; leaves time at edge + 1.
  task automatic tick();
    logic [7:0] nd, iq, idd, ev, w1c;
    logic       ni;
    int         p, r;
    if (rst_n) begin
      p  = int'(addr >> 3);
      r  = int'(addr[2:0]);
      nd = m_read(p, r);
      ni = 1'b0;
      for (int q = 0; q < PORTS; q++) ni = ni | (|(m_flag[q] & m_ie[q]));
      for (int q = 0; q < PORTS; q++) begin
        iq  = m_hist[S-1][8*q +: 8];
        idd = m_hist[S][8*q +: 8];
        ev  = (m_edges >= S + 1) ? ((m_edg[q] & idd & ~iq) | (~m_edg[q] & iq & ~idd)) : 8'h00;
        w1c = 8'h00;
        if (cs && we && p == q) begin
          case (r)
            0: m_out[q] = din;
            1: m_dir[q] = din;
            3: m_out[q] = m_out[q] | din;
            4: m_out[q] = m_out[q] & ~din;
            5: m_ie[q]  = din;
            6: m_edg[q] = din;
            7: w1c      = din;
            default: ;
          endcase
        end
        m_flag[q] = (m_flag[q] & ~w1c) | ev;
      end
      m_dout = nd;
      m_irq  = ni;
      m_hist.push_front(gpio_i);
      void'(m_hist.pop_back());
      m_edges++;
    end
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
  endtask

  task automatic wr(int p, int r, logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = AW'(p * 8 + r); din = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(int p, int r);
    cs = 1'b1; we = 1'b0; addr = AW'(p * 8 + r);
    tick();
    cs = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0; gpio_i = '1;
    #1;
    n_total++; if (gpio_o !== '0) $display("FAIL rst_gpio_o got %h exp 0", gpio_o); else n_pass++;
    n_total++; if (gpio_oe !== '0) $display("FAIL rst_gpio_oe got %h exp 0", gpio_oe); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL rst_irq got %b exp 0", irq); else n_pass++;
    n_total++; if (dout !== 8'h00) $display("FAIL rst_dout got %h exp 00", dout); else n_pass++;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    n_total++; if (gpio_o !== '0 || gpio_oe !== '0) $display("FAIL post_rst_pins got %h/%h exp 0/0", gpio_o, gpio_oe); else n_pass++;
    n_total++; if (irq !== 1'b0) $display("FAIL post_rst_irq got %b exp 0", irq); else n_pass++;
    for (int p = 0; p < PORTS; p++) begin
      rd(p, 7);
      n_total++; if (dout !== 8'h00) $display("FAIL rst_flag%0d got %h exp 00", p, dout); else n_pass++;
    end
    gpio_i = '0;
    repeat (S + 3) tick();
  endtask

  task automatic test_port0_writes();
    wr(0, 0, 8'hA5);
    wr(0, 3, 8'h0A);
    wr(0, 4, 8'h81);
    n_total++; if (gpio_o[7:0] !== m_out[0]) $display("FAIL set_clr_gpio_o got %h exp %h", gpio_o[7:0], m_out[0]); else n_pass++;
    rd(0, 0);
    n_total++; if (dout !== m_out[0]) $display("FAIL read_out got %h exp %h", dout, m_out[0]); else n_pass++;
    rd(0, 3);
    n_total++; if (dout !== m_out[0]) $display("FAIL read_set got %h exp %h", dout, m_out[0]); else n_pass++;
  endtask

  task automatic test_port1_input();
    wr(1, 1, 8'h0F);
    n_total++; if (gpio_oe[15:8] !== 8'h0F) $display("FAIL dir_oe got %h exp 0f", gpio_oe[15:8]); else n_pass++;
    addr = AW'(1 * 8 + 2);
    gpio_i[15:8] = 8'h3C;
    for (int k = 1; k <= S; k++) begin
      tick();
      n_total++; if (dout === 8'h3C) $display("FAIL in_early cycle %0d got %h exp not 3c", k, dout); else n_pass++;
    end
    tick();
    n_total++; if (dout !== 8'h3C) $display("FAIL in_sync got %h exp 3c", dout); else n_pass++;
  endtask

  task automatic test_irq();
    int waited;
    wr(0, 5, 8'h01);
    wr(0, 6, 8'h00);
    addr = AW'(7);
    gpio_i[0] = 1'b1;
    waited = 0;
    while (irq !== 1'b1 && waited < 10) begin
      tick(); waited++;
      n_total++; if (irq !== m_irq || dout !== m_dout) $display("FAIL rise_track got %b/%h exp %b/%h", irq, dout, m_irq, m_dout); else n_pass++;
    end
    n_total++; if (irq !== 1'b1 || dout !== 8'h01) $display("FAIL rise_irq got %b/%h exp 1/01", irq, dout); else n_pass++;
    gpio_i[0] = 1'b0;
    wr(0, 7, 8'h01);
    n_total++; if (irq !== 1'b1) $display("FAIL w1c_irq_lag got %b exp 1", irq); else n_pass++;
    rd(0, 7);
    n_total++; if (irq !== 1'b0 || dout !== 8'h00) $display("FAIL w1c_clear got %b/%h exp 0/00", irq, dout); else n_pass++;
    repeat (S + 2) tick();
    wr(0, 6, 8'h01);
    gpio_i[0] = 1'b1;
    repeat (S + 3) tick();
    rd(0, 7);
    n_total++; if (irq !== 1'b0 || dout !== 8'h00) $display("FAIL fall_mode_rise got %b/%h exp 0/00", irq, dout); else n_pass++;
    gpio_i[0] = 1'b0;
    repeat (S + 3) tick();
    rd(0, 7);
    n_total++; if (irq !== 1'b1 || dout !== 8'h01) $display("FAIL fall_mode_fall got %b/%h exp 1/01", irq, dout); else n_pass++;
    wr(0, 7, 8'h01);
    wr(0, 6, 8'h00);
    repeat (2) tick();
  endtask

  task automatic test_collision();
    gpio_i[0] = 1'b1;
    repeat (S) tick();
    wr(0, 7, 8'h01);
    rd(0, 7);
    n_total++; if (dout !== 8'h01) $display("FAIL collision_flag got %h exp 01", dout); else n_pass++;
    n_total++; if (irq !== m_irq) $display("FAIL collision_irq got %b exp %b", irq, m_irq); else n_pass++;
    wr(0, 7, 8'h01);
    tick();
  endtask

  task automatic test_unmapped();
    rd(3, 0);
    n_total++; if (dout !== 8'h00) $display("FAIL unmapped_read got %h exp 00", dout); else n_pass++;
    for (int r = 0; r < 8; r++) wr(3, r, 8'hFF);
    n_total++; if (gpio_o !== m_gpio_o() || gpio_oe !== m_gpio_oe()) $display("FAIL unmapped_pins got %h/%h exp %h/%h", gpio_o, gpio_oe, m_gpio_o(), m_gpio_oe()); else n_pass++;
    for (int p = 0; p < PORTS; p++) begin
      for (int r = 0; r < 8; r++) begin
        rd(p, r);
        n_total++; if (dout !== m_dout) $display("FAIL unmapped_regs p%0d r%0d got %h exp %h", p, r, dout, m_dout); else n_pass++;
      end
    end
    cs = 1'b1; we = 1'b1; addr = AW'(1); din = 8'h55;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (gpio_o !== '0 || gpio_oe !== '0 || irq !== 1'b0 || dout !== 8'h00) $display("FAIL midreset got %h/%h/%b/%h exp all 0", gpio_o, gpio_oe, irq, dout); else n_pass++;
    tick();
    cs = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    rd(0, 0);
    n_total++; if (dout !== 8'h00) $display("FAIL midreset_out got %h exp 00", dout); else n_pass++;
    rd(0, 1);
    n_total++; if (dout !== 8'h00) $display("FAIL midreset_dir got %h exp 00", dout); else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      cs   = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 31));
      din  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) gpio_i = (8*PORTS)'($urandom);
      tick();
      n_total++; if (dout !== m_dout) $display("FAIL rnd_dout cyc %0d got %h exp %h", k, dout, m_dout); else n_pass++;
      n_total++; if (gpio_o !== m_gpio_o()) $display("FAIL rnd_gpio_o cyc %0d got %h exp %h", k, gpio_o, m_gpio_o()); else n_pass++;
      n_total++; if (gpio_oe !== m_gpio_oe()) $display("FAIL rnd_gpio_oe cyc %0d got %h exp %h", k, gpio_oe, m_gpio_oe()); else n_pass++;
      n_total++; if (irq !== m_irq) $display("FAIL rnd_irq cyc %0d got %b exp %b", k, irq, m_irq); else n_pass++;
    end
    cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_port0_writes();
    test_port1_input();
    test_irq();
    test_collision();
    test_unmapped();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
